frame_loader: RTL and testbench
===============================

// Module: frame_loader
// PURPOSE
//  Upstream stage of the RGB panel display. Receives a byte stream from the host link
//  (UART/SPI front end) and assembles it into 24-bit framebuffer words. Writes each word
//  sequentially into the display dual-port memory via its write port (addr/data/wr_en).
//  A word holds two RGB444 pixels: [23:12] top-half pixel, [11:0] bottom-half pixel.
// PARAMETERS
//  WIDTH    96  panel columns (x CHAINED)
//  HEIGHT   48  panel rows; words per frame = WIDTH*HEIGHT/2 (2304 by default)
//  CHAINED  1   panels in chain; WORDS = WIDTH*CHAINED*HEIGHT/2, must be <= 4096
// PORTS
//  i_clk         in   1   system clock (same clock as the display memory)
//  i_rst         in   1   synchronous, active-high reset
//  i_byte        in   8   stream byte
//  i_byte_valid  in   1   i_byte valid this cycle
//  i_byte_sof    in   1   qualifies i_byte as first byte of a frame
//  o_ready       out  1   loader accepts a byte when valid && ready
//  o_addr        out  12  memory write address
//  o_data        out  24  memory write data
//  o_wr_en       out  1   one-cycle write strobe
//  o_frame_done  out  1   one-cycle pulse: frame complete (and checksum passed, if enabled)
//  o_err         out  1   sticky error flag; cleared by reset or by an accepted SOF byte
// BEHAVIOUR
//  - Reset: all outputs 0, o_ready 0 during the reset cycle, 1 from the first cycle after.
//    State IDLE, address and byte counters 0, partial word discarded.
//  - o_ready is 1 whenever out of reset. The memory accepts a write every cycle, so there is no backpressure.
//  - States: IDLE -> B0 -> B1 -> B2 -> (B0 | CHK | IDLE).
//    IDLE: non-SOF bytes are dropped and o_err is set. A SOF byte clears o_err and
//    zeroes addr, and is taken as byte 0 of word 0 (goes to B1).
//  - Byte order is MSB first: byte0 -> [23:16], byte1 -> [15:8], byte2 -> [7:0].
//  - Write latency: third byte accepted in cycle n -> o_wr_en=1 in cycle n+1, with o_addr and o_data registered.
//    o_addr increments after each write.
//  - Last word (addr = WORDS-1): after its write the loader goes to IDLE. Without the
//    checksum option, o_frame_done is asserted in the same cycle as that o_wr_en.
//  - SOF in any non-IDLE state: the partial word is discarded without a write and addr
//    restarts at 0. The SOF byte is byte 0. No error.
//  - i_byte_sof with i_byte_valid=0 is ignored.
//  - Address never wraps: bytes after the last word (no SOF) are dropped in IDLE and set o_err.
// CONFIGURATION
//  FRAME_LOADER_CHECKSUM_EN defined:
//  - A running XOR of all payload bytes of the frame is kept; SOF reseeds it with the SOF byte.
//  - After the last word the loader enters CHK and takes one more byte, the checksum.
//  - Match: o_frame_done is pulsed in the cycle after that byte is accepted.
//  - Mismatch: o_err is set and there is no o_frame_done. Both cases go to IDLE.
//  - A SOF byte in CHK restarts the frame.
//  - Memory writes are never suppressed.
//  Not defined: there is no CHK state and no checksum logic; done behaves as above.
// STRUCTURE
//  - Package rgb_pkg: loader_state_t enum (IDLE,B0,B1,B2,CHK); WORDS_PER_FRAME
//    function of WIDTH/HEIGHT/CHAINED; ADDR_W=12; DATA_W=24.
//  - Sub-module byte_packer: shift/assemble of 3 bytes into 24 bits with a word_valid pulse.
//    The FSM, address counter and checksum stay in frame_loader.
// TESTING
//  - Reset, then a full frame (SOF + 6912 bytes, ramp) -> 2304 writes.
//    Word k: addr=k, data={k[11:0],~k[11:0]}. o_frame_done pulses once, with write 2303.
//  - Bytes 0xAA,0xBB,0xCC with no SOF -> no writes; o_err=1. A following SOF byte clears o_err.
//  - SOF, 4 bytes, SOF + 3 bytes 0x12,0x34,0x56 -> exactly one extra write, at addr 1?
//    No: addr 0 data 0x123456. The first word is written once, then overwritten at addr 0.
//  - i_rst asserted mid-frame (after 100 words) -> all outputs 0 next cycle. The next
//    non-SOF byte is dropped with o_err=1.
//  - CHECKSUM_EN: correct XOR byte -> o_frame_done 1 cycle after acceptance.
//    Correct value ^ 0x01 -> o_err=1, no done pulse.
//  - Back-to-back valid every cycle -> a write every 3rd cycle, never 2 writes in
//    consecutive cycles; o_ready is never low.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared types and sizing helpers for the RGB panel frame loader.
package rgb_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 24;

    typedef enum logic [2:0] {IDLE, B0, B1, B2, CHK} loader_state_t;

    function automatic int words_per_frame(input int width, input int height, input int chained);
        return (width * chained * height) / 2;
    endfunction
endpackage

// File: rtl/frame_loader_if.sv
// Byte-stream input and display-memory write port of the frame loader.
interface frame_loader_if;
    import rgb_pkg::*;

    logic [7:0]        i_byte;
    logic              i_byte_valid;
    logic              i_byte_sof;
    logic              o_ready;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_data;
    logic              o_wr_en;
    logic              o_frame_done;
    logic              o_err;

    modport master (
        output i_byte, i_byte_valid, i_byte_sof,
        input  o_ready, o_addr, o_data, o_wr_en, o_frame_done, o_err
    );

    modport slave (
        input  i_byte, i_byte_valid, i_byte_sof,
        output o_ready, o_addr, o_data, o_wr_en, o_frame_done, o_err
    );
endinterface

// File: rtl/frame_loader_packer.sv
// byte_packer: collects three MSB-first bytes into a 24-bit word, registered output.
module byte_packer
    import rgb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [1:0]        i_idx,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_valid
);
    logic [7:0]        r_b0;
    logic [7:0]        r_b1;
    logic [DATA_W-1:0] r_word;
    logic              r_vld;

    // A restart at index 0 simply overwrites r_b0, so a partial word never escapes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_b0   <= 8'd0;
            r_b1   <= 8'd0;
            r_word <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (i_load) begin
                case (i_idx)
                    2'd0:    r_b0 <= i_byte;
                    2'd1:    r_b1 <= i_byte;
                    default: begin
                        r_word <= {r_b0, r_b1, i_byte};
                        r_vld  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_vld;
endmodule

// File: rtl/frame_loader.sv
// Assembles host bytes into framebuffer words and writes them sequentially.
// Optional trailing XOR checksum byte: define FRAME_LOADER_CHECKSUM_EN.
module frame_loader
    import rgb_pkg::*;
#(
    parameter int WIDTH   = 96,
    parameter int HEIGHT  = 48,
    parameter int CHAINED = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    frame_loader_if.slave  io
);
    // WORDS must not exceed 4096 so the last address fits in ADDR_W bits.
    localparam int                WORDS     = words_per_frame(WIDTH, HEIGHT, CHAINED);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    loader_state_t     r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_ready;
    logic              r_done;
    logic              r_err;
`ifdef FRAME_LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
`endif

    logic              w_acc;
    logic              w_load;
    logic [1:0]        w_idx;
    logic [DATA_W-1:0] w_word;
    logic              w_word_valid;

    assign w_acc = io.i_byte_valid && r_ready;

    always_comb begin
        w_load = 1'b0;
        w_idx  = 2'd0;
        if (w_acc) begin
            if (io.i_byte_sof) begin
                w_load = 1'b1;
            end else begin
                case (r_state)
                    B0:      w_load = 1'b1;
                    B1:      begin w_load = 1'b1; w_idx = 2'd1; end
                    B2:      begin w_load = 1'b1; w_idx = 2'd2; end
                    default: w_load = 1'b0;
                endcase
            end
        end
    end

    byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (w_load),
        .i_idx        (w_idx),
        .i_byte       (io.i_byte),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wr_addr <= '0;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
            r_xor     <= 8'd0;
`endif
        end else begin
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            if (w_acc) begin
                if (io.i_byte_sof) begin
                    // SOF restarts from any state and is byte 0 of word 0.
                    r_state <= B1;
                    r_addr  <= '0;
                    r_err   <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
                    r_xor   <= io.i_byte;
`endif
                end else begin
                    case (r_state)
                        IDLE: r_err <= 1'b1;
                        B0: begin
                            r_state <= B1;
`ifdef FRAME_LOADER_CHECKSUM_EN
                            r_xor   <= r_xor ^ io.i_byte;
`endif
                        end
                        B1: begin
                            r_state <= B2;
`ifdef FRAME_LOADER_CHECKSUM_EN
                            r_xor   <= r_xor ^ io.i_byte;
`endif
                        end
                        B2: begin
                            r_wr_addr <= r_addr;
`ifdef FRAME_LOADER_CHECKSUM_EN
                            r_xor     <= r_xor ^ io.i_byte;
`endif
                            if (r_addr == LAST_ADDR) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
                                r_state <= CHK;
`else
                                r_state <= IDLE;
                                r_done  <= 1'b1;
`endif
                            end else begin
                                r_addr  <= r_addr + 1'b1;
                                r_state <= B0;
                            end
                        end
`ifdef FRAME_LOADER_CHECKSUM_EN
                        CHK: begin
                            r_state <= IDLE;
                            if (io.i_byte == r_xor) r_done <= 1'b1;
                            else                    r_err  <= 1'b1;
                        end
`endif
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign io.o_ready      = r_ready;
    assign io.o_addr       = r_wr_addr;
    assign io.o_data       = w_word;
    assign io.o_wr_en      = w_word_valid;
    assign io.o_frame_done = r_done;
    assign io.o_err        = r_err;
endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: full ramp frame, error paths, restart, reset.
module tb_frame_loader;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] xsum;

`ifdef FRAME_LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    frame_loader_if io ();

    frame_loader u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle; outputs are examined 1 ns after the edge.
    task automatic sendb(input logic [7:0] b, input logic s);
        io.i_byte       = b;
        io.i_byte_valid = 1'b1;
        io.i_byte_sof   = s;
        if (s) xsum = b;
        else   xsum = xsum ^ b;
        @(posedge clk);
        #1;
        io.i_byte_valid = 1'b0;
        io.i_byte_sof   = 1'b0;
    endtask

    task automatic send_word(input int k, input logic s, input logic last);
        logic [23:0] w;
        w = {k[11:0], ~k[11:0]};
        sendb(w[23:16], s);
        chk("wr_b0", 32'(io.o_wr_en), 32'd0);
        sendb(w[15:8], 1'b0);
        chk("wr_b1", 32'(io.o_wr_en), 32'd0);
        sendb(w[7:0], 1'b0);
        chk("wr_en", 32'(io.o_wr_en), 32'd1);
        chk("addr", 32'(io.o_addr), 32'(k[11:0]));
        chk("data", 32'(io.o_data), 32'(w));
        chk("done", 32'(io.o_frame_done), 32'(last && !CS_EN));
        chk("ready", 32'(io.o_ready), 32'd1);
    endtask

    initial begin
        io.i_byte       = 8'd0;
        io.i_byte_valid = 1'b0;
        io.i_byte_sof   = 1'b0;
        xsum            = 8'd0;
        rst             = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(io.o_ready), 32'd0);
        chk("rst_wr", 32'(io.o_wr_en), 32'd0);
        chk("rst_addr", 32'(io.o_addr), 32'd0);
        chk("rst_data", 32'(io.o_data), 32'd0);
        chk("rst_done", 32'(io.o_frame_done), 32'd0);
        chk("rst_err", 32'(io.o_err), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(io.o_ready), 32'd1);

        // Full ramp frame, bytes back to back
        for (int k = 0; k < 2304; k++) send_word(k, k == 0, k == 2303);
`ifdef FRAME_LOADER_CHECKSUM_EN
        sendb(xsum, 1'b0);
        chk("cs_done", 32'(io.o_frame_done), 32'd1);
        chk("cs_err", 32'(io.o_err), 32'd0);
        chk("cs_wr", 32'(io.o_wr_en), 32'd0);
`endif
        @(posedge clk);
        #1;
        chk("done_single", 32'(io.o_frame_done), 32'd0);
        chk("frame_err", 32'(io.o_err), 32'd0);
`ifdef FRAME_LOADER_CHECKSUM_EN
        for (int k = 0; k < 2304; k++) send_word(k, k == 0, k == 2303);
        sendb(xsum ^ 8'h01, 1'b0);
        chk("csbad_done", 32'(io.o_frame_done), 32'd0);
        chk("csbad_err", 32'(io.o_err), 32'd1);
`endif

        // Bytes after the frame without SOF are dropped and flag an error
        sendb(8'hAA, 1'b0);
        chk("nosof_wr0", 32'(io.o_wr_en), 32'd0);
        sendb(8'hBB, 1'b0);
        chk("nosof_wr1", 32'(io.o_wr_en), 32'd0);
        sendb(8'hCC, 1'b0);
        chk("nosof_wr2", 32'(io.o_wr_en), 32'd0);
        chk("nosof_err", 32'(io.o_err), 32'd1);
        sendb(8'h01, 1'b1);
        chk("sof_clr_err", 32'(io.o_err), 32'd0);
        chk("sof_wr", 32'(io.o_wr_en), 32'd0);

        // SOF + 4 bytes, then SOF restart: word 0 rewritten
        sendb(8'h02, 1'b0);
        sendb(8'h03, 1'b0);
        chk("w0_wr", 32'(io.o_wr_en), 32'd1);
        chk("w0_addr", 32'(io.o_addr), 32'd0);
        chk("w0_data", 32'(io.o_data), 32'h010203);
        sendb(8'h04, 1'b0);
        sendb(8'h05, 1'b0);
        chk("partial_wr", 32'(io.o_wr_en), 32'd0);
        sendb(8'h12, 1'b1);
        chk("restart_wr", 32'(io.o_wr_en), 32'd0);
        sendb(8'h34, 1'b0);
        chk("restart_wr1", 32'(io.o_wr_en), 32'd0);
        sendb(8'h56, 1'b0);
        chk("restart_wr2", 32'(io.o_wr_en), 32'd1);
        chk("restart_addr", 32'(io.o_addr), 32'd0);
        chk("restart_data", 32'(io.o_data), 32'h123456);
        chk("restart_err", 32'(io.o_err), 32'd0);

        // Words 1..99; a SOF without valid in the middle is ignored
        for (int k = 1; k <= 50; k++) send_word(k, 1'b0, 1'b0);
        io.i_byte_sof = 1'b1;
        @(posedge clk);
        #1;
        io.i_byte_sof = 1'b0;
        chk("sof_novalid_wr", 32'(io.o_wr_en), 32'd0);
        for (int k = 51; k <= 99; k++) send_word(k, 1'b0, 1'b0);

        // Reset mid-frame
        sendb(8'hEE, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_ready", 32'(io.o_ready), 32'd0);
        chk("mrst_wr", 32'(io.o_wr_en), 32'd0);
        chk("mrst_addr", 32'(io.o_addr), 32'd0);
        chk("mrst_data", 32'(io.o_data), 32'd0);
        chk("mrst_done", 32'(io.o_frame_done), 32'd0);
        chk("mrst_err", 32'(io.o_err), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sendb(8'h77, 1'b0);
        chk("post_rst_wr", 32'(io.o_wr_en), 32'd0);
        chk("post_rst_err", 32'(io.o_err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
